// File: rtl/aritmetica_mac_pipe_if.sv
// Sample/result bundle between the coefficient sequencer and the MAC stage.
interface aritmetica_mac_pipe_if #(
    parameter int N = 25
);
    logic                  in_valid;
    logic                  mode;
    logic                  acc_clr;
    logic signed [N-1:0]   x_in;
    logic signed [N-1:0]   m_in;
    logic signed [N-1:0]   c_in;
    logic                  out_valid;
    logic signed [2*N-1:0] out_full;
    logic signed [N-1:0]   out_q;
    logic                  sat;

    modport master (
        output in_valid, mode, acc_clr, x_in, m_in, c_in,
        input  out_valid, out_full, out_q, sat
    );

    modport slave (
        input  in_valid, mode, acc_clr, x_in, m_in, c_in,
        output out_valid, out_full, out_q, sat
    );
endinterface

// File: rtl/aritmetica_mac_pipe.sv
// Pipelined y = c + m*x with optional accumulation, full and rounded/saturated outputs.
// Latency 2 cycles, one sample per cycle, no backpressure.
module aritmetica_mac_pipe #(
    parameter int N = 25,
    parameter int F = 12,
    parameter int G = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    aritmetica_mac_pipe_if.slave mac
);
    localparam int W2    = 2 * N;
    localparam int ACC_W = 2 * N + G;
    localparam int SW    = ACC_W + 1;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (F - 1);

    // Stage 1
    logic                 s1_vld_q;
    logic                 mode_q, mode_d;
    logic                 clr_q, clr_d;
    logic signed [W2-1:0] prod_q, prod_d;
    logic signed [W2-1:0] cal_q, cal_d;
    logic signed [W2-1:0] x_ext, m_ext;

    // Stage 2 / output
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q;
    logic signed [W2-1:0]    out_full_q, out_full_d;
    logic signed [N-1:0]     out_q_q, out_q_d;
    logic                    sat_q, sat_d;

    logic signed [SW-1:0]    base_w, sum_w, s_w, rnd_w, shf_w;
    logic signed [ACC_W-1:0] s_acc;
    logic                    acc_ovf, full_ovf, q_ovf;

    always_comb begin
        x_ext  = {{N{mac.x_in[N-1]}}, mac.x_in};
        m_ext  = {{N{mac.m_in[N-1]}}, mac.m_in};
        prod_d = prod_q;
        cal_d  = cal_q;
        mode_d = mode_q;
        clr_d  = clr_q;
        if (mac.in_valid) begin
            prod_d = x_ext * m_ext;
            cal_d  = {{(W2-N-F){mac.c_in[N-1]}}, mac.c_in, {F{1'b0}}};
            mode_d = mac.mode;
            clr_d  = mac.acc_clr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q <= 1'b0;
            prod_q   <= '0;
            cal_q    <= '0;
            mode_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            s1_vld_q <= mac.in_valid;
            prod_q   <= prod_d;
            cal_q    <= cal_d;
            mode_q   <= mode_d;
            clr_q    <= clr_d;
        end
    end

    // Mode-0 sums never reach the accumulator range (G >= 1), so one saturation path serves both modes.
    always_comb begin
        base_w = '0;
        if (mode_q && !clr_q) begin
            base_w = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        end
        sum_w   = base_w
                + {{(SW-W2){prod_q[W2-1]}}, prod_q}
                + {{(SW-W2){cal_q[W2-1]}}, cal_q};
        acc_ovf = sum_w[SW-1] ^ sum_w[SW-2];
        s_acc   = acc_ovf ? {sum_w[SW-1], {(ACC_W-1){~sum_w[SW-1]}}}
                          : sum_w[ACC_W-1:0];
        s_w     = {s_acc[ACC_W-1], s_acc};

        full_ovf   = (s_w[SW-1:W2-1] != {(SW-W2+1){s_w[SW-1]}});
        out_full_d = full_ovf ? {s_w[SW-1], {(W2-1){~s_w[SW-1]}}}
                              : s_w[W2-1:0];

        rnd_w   = s_w + HALF;
        shf_w   = rnd_w >>> F;
        q_ovf   = (shf_w[SW-1:N-1] != {(SW-N+1){shf_w[SW-1]}});
        out_q_d = q_ovf ? {shf_w[SW-1], {(N-1){~shf_w[SW-1]}}}
                        : shf_w[N-1:0];

        sat_d = acc_ovf | full_ovf | q_ovf;

        acc_d = acc_q;
        if (s1_vld_q && mode_q) begin
            acc_d = s_acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_full_q  <= '0;
            out_q_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_full_q <= out_full_d;
                out_q_q    <= out_q_d;
                sat_q      <= sat_d;
            end
        end
    end

    assign mac.out_valid = out_valid_q;
    assign mac.out_full  = out_full_q;
    assign mac.out_q     = out_q_q;
    assign mac.sat       = sat_q;
endmodule

// File: tb/tb_aritmetica_mac_pipe.sv
// Directed bench for aritmetica_mac_pipe: drives and samples on the falling edge.
module tb_aritmetica_mac_pipe;
    localparam int N = 25;
    localparam int F = 12;
    localparam int G = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    aritmetica_mac_pipe_if #(.N(N)) mac_if ();

    aritmetica_mac_pipe #(.N(N), .F(F), .G(G)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mac     (mac_if)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input longint q, input longint full, input longint s);
        chk({tag, "_vld"},  mac_if.out_valid, 1);
        chk({tag, "_q"},    mac_if.out_q,     q);
        chk({tag, "_full"}, mac_if.out_full,  full);
        chk({tag, "_sat"},  mac_if.sat,       s);
    endtask

    task automatic drive(input logic md, input logic clr, input int x, input int m, input int c);
        mac_if.in_valid = 1'b1;
        mac_if.mode     = md;
        mac_if.acc_clr  = clr;
        mac_if.x_in     = N'(x);
        mac_if.m_in     = N'(m);
        mac_if.c_in     = N'(c);
    endtask

    // Idle cycles carry junk on the qualified fields; it must be ignored.
    task automatic idle();
        mac_if.in_valid = 1'b0;
        mac_if.mode     = 1'b1;
        mac_if.acc_clr  = 1'b1;
        mac_if.x_in     = N'(12345);
        mac_if.m_in     = N'(-777);
        mac_if.c_in     = N'(99);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_vld",  mac_if.out_valid, 0);
        chk("rst_full", mac_if.out_full,  0);
        chk("rst_q",    mac_if.out_q,     0);
        chk("rst_sat",  mac_if.sat,       0);
        reset_n = 1'b1;

        // Single product, latency and one-cycle pulse
        @(negedge clk); drive(0, 0, 4096, 8192, 2048);
        @(negedge clk); chk("t1_early_vld", mac_if.out_valid, 0); idle();
        @(negedge clk); chk_res("t1", 10240, 41943040, 0);
        @(negedge clk); chk("t1_pulse_vld", mac_if.out_valid, 0);
                        chk("t1_hold_q", mac_if.out_q, 10240);

        // Sign and saturation, back-to-back
        @(negedge clk); drive(0, 0, -4096, 8192, 0);
        @(negedge clk); drive(0, 0, 16777215, 16777215, 0);
        @(negedge clk); chk_res("t2_neg", -8192, -33554432, 0);
                        drive(0, 0, -16777216, 16777215, 0);
        @(negedge clk); chk_res("t2_posmax", 16777215, 64'sd281474943156225, 1); idle();
        @(negedge clk); chk_res("t2_negmax", -16777216, -64'sd281474959933440, 1);

        // Round half up
        @(negedge clk); drive(0, 0, 1, 2048, 0);
        @(negedge clk); drive(0, 0, -1, 2048, 0);
        @(negedge clk); chk_res("t3_half_pos", 1, 2048, 0); drive(0, 0, 1, 1024, 0);
        @(negedge clk); chk_res("t3_half_neg", 0, -2048, 0); idle();
        @(negedge clk); chk_res("t3_quarter", 0, 1024, 0);

        // Back-to-back accumulation and restart
        @(negedge clk); drive(1, 1, 4096, 4096, 0);
        @(negedge clk); drive(1, 0, 4096, 4096, 0);
        @(negedge clk); chk_res("t4_a", 4096, 16777216, 0);  drive(1, 0, 4096, 4096, 0);
        @(negedge clk); chk_res("t4_b", 8192, 33554432, 0);  drive(1, 1, 4096, 4096, 0);
        @(negedge clk); chk_res("t4_c", 12288, 50331648, 0); idle();
        @(negedge clk); chk_res("t4_clr", 4096, 16777216, 0);

        // Mode-0 sample interleaved in an accumulation
        @(negedge clk); drive(1, 1, 4096, 4096, 0);
        @(negedge clk); drive(1, 0, 4096, 4096, 0);
        @(negedge clk); chk_res("t5_a", 4096, 16777216, 0);  drive(0, 0, 4096, 4096, 4096);
        @(negedge clk); chk_res("t5_b", 8192, 33554432, 0);  drive(1, 0, 4096, 4096, 0);
        @(negedge clk); chk_res("t5_m0", 8192, 33554432, 0); idle();
        @(negedge clk); chk_res("t5_c", 12288, 50331648, 0);

        // Asynchronous reset with samples in flight
        @(negedge clk); drive(1, 0, 4096, 4096, 0);
        @(negedge clk); drive(1, 0, 4096, 4096, 0);
        @(negedge clk); chk_res("t6_pre", 16384, 67108864, 0); idle();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_vld",  mac_if.out_valid, 0);
        chk("t6_rst_q",    mac_if.out_q,     0);
        chk("t6_rst_full", mac_if.out_full,  0);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk($sformatf("t6_drain_vld%0d", i), mac_if.out_valid, 0);
        end
        @(negedge clk); drive(1, 0, 4096, 4096, 0);
        @(negedge clk); idle();
        @(negedge clk); chk_res("t6_acc_cleared", 4096, 16777216, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
